// File: rtl/cpu_pkg.sv
// Shared definitions for the teaching-CPU control unit: widths, opcodes,
// sequencer states and the instruction word layout.
package cpu_pkg;

    localparam int CPU_DATA_W = 8;
    localparam int CPU_PC_W   = 8;
    localparam int CPU_OP_W   = 3;
    localparam int CPU_NREG   = 4;

    // Opcode numbering is shared with the ALU FS input.
    typedef enum logic [CPU_OP_W-1:0] {
        OP_MOV = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_NOT = 3'b100,
        OP_ABS = 3'b101,
        OP_NEG = 3'b110,
        OP_HLT = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    // Field order maps straight onto Instr_in[7:0].
    typedef struct packed {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic       rsvd;
    } instr_t;

    function automatic logic is_halt(input instr_t ir);
        return ir.op == OP_HLT;
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 4x8 register file: one write port where writeback beats an external
// preload to the same register, two operand reads and one debug read.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int NREG   = CPU_NREG,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wb_en_i,
    input  logic [AW-1:0]     wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              ld_en_i,
    input  logic [AW-1:0]     ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic [AW-1:0]     rs_addr_i,
    input  logic [AW-1:0]     rd_addr_i,
    input  logic [AW-1:0]     dbg_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [NREG-1:0][DATA_W-1:0] regs_q;

    // A load is dropped only when it targets the register being written back.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wb_en_i && wb_addr_i == AW'(i))
                    regs_q[i] <= wb_data_i;
                else if (ld_en_i && ld_addr_i == AW'(i))
                    regs_q[i] <= ld_data_i;
            end
        end
    end

    assign rs_data_o  = regs_q[rs_addr_i];
    assign rd_data_o  = regs_q[rd_addr_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute/writeback sequencer feeding the 8-bit ALU and
// writing its registered result back into the register file.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int PC_W   = CPU_PC_W,
    parameter int OP_W   = CPU_OP_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic              Instr_req,
    output logic [PC_W-1:0]   Instr_addr,
    input  logic              Instr_ack,
    input  logic [7:0]        Instr_in,
    output logic [OP_W-1:0]   FS,
    output logic              Enable_cal,
    output logic [DATA_W-1:0] Data_A,
    output logic [DATA_W-1:0] Data_B,
    input  logic [DATA_W-1:0] Result_in,
    input  logic              Ld_en,
    input  logic [1:0]        Ld_addr,
    input  logic [DATA_W-1:0] Ld_data,
    input  logic [1:0]        Dbg_sel,
    output logic [DATA_W-1:0] Dbg_out,
    output logic              Halted,
    output logic [PC_W-1:0]   PC_out
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    instr_t            ir_q, ir_d;
    logic [OP_W-1:0]   fs_q, fs_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] rs_data, rd_data;
    logic              wb_en;
    logic              unused_rsvd;

    assign unused_rsvd = ir_q.rsvd;
    assign wb_en       = (state_q == ST_WB);

    cpu_regfile #(
        .DATA_W (DATA_W),
        .NREG   (CPU_NREG)
    ) u_regfile (
        .clk_i      (CLK),
        .rst_ni     (RST_N),
        .wb_en_i    (wb_en),
        .wb_addr_i  (ir_q.rd),
        .wb_data_i  (Result_in),
        .ld_en_i    (Ld_en),
        .ld_addr_i  (Ld_addr),
        .ld_data_i  (Ld_data),
        .rs_addr_i  (ir_q.rs),
        .rd_addr_i  (ir_q.rd),
        .dbg_addr_i (Dbg_sel),
        .rs_data_o  (rs_data),
        .rd_data_o  (rd_data),
        .dbg_data_o (Dbg_out)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            fs_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            fs_q    <= fs_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        fs_d    = fs_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            ST_FETCH: begin
                if (Instr_ack) begin
                    ir_d    = instr_t'(Instr_in);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // HLT never reaches the ALU and leaves the PC on itself.
                if (is_halt(ir_q)) begin
                    state_d = ST_HALT;
                end else begin
                    a_d     = rs_data;
                    b_d     = rd_data;
                    fs_d    = OP_W'(ir_q.op);
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC:  state_d = ST_WB;
            ST_WB:    state_d = ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
        endcase
    end

    // Request is gated by reset so it reads 0 while RST_N is held low.
    assign Instr_req  = (state_q == ST_FETCH) && RST_N;
    assign Instr_addr = pc_q;
    assign PC_out     = pc_q;
    assign Enable_cal = (state_q == ST_EXEC);
    assign Halted     = (state_q == ST_HALT);
    assign FS         = fs_q;
    assign Data_A     = a_q;
    assign Data_B     = b_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit with a small behavioural ALU model.
module tb_cpu_control_unit;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       Instr_req;
    logic [7:0] Instr_addr;
    logic       Instr_ack;
    logic [7:0] Instr_in;
    logic [2:0] FS;
    logic       Enable_cal;
    logic [7:0] Data_A, Data_B;
    logic [7:0] Result_in;
    logic       Ld_en;
    logic [1:0] Ld_addr;
    logic [7:0] Ld_data;
    logic [1:0] Dbg_sel;
    logic [7:0] Dbg_out;
    logic       Halted;
    logic [7:0] PC_out;

    int checks = 0;
    int errors = 0;
    int en_count = 0;

    always #5 CLK = ~CLK;

    cpu_control_unit dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .Instr_req  (Instr_req),
        .Instr_addr (Instr_addr),
        .Instr_ack  (Instr_ack),
        .Instr_in   (Instr_in),
        .FS         (FS),
        .Enable_cal (Enable_cal),
        .Data_A     (Data_A),
        .Data_B     (Data_B),
        .Result_in  (Result_in),
        .Ld_en      (Ld_en),
        .Ld_addr    (Ld_addr),
        .Ld_data    (Ld_data),
        .Dbg_sel    (Dbg_sel),
        .Dbg_out    (Dbg_out),
        .Halted     (Halted),
        .PC_out     (PC_out)
    );

    function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b000:  return a;
            3'b001:  return b + a;
            3'b010:  return b - a;
            3'b011:  return b & a;
            3'b100:  return ~a;
            3'b101:  return a[7] ? -a : a;
            3'b110:  return -a;
            default: return 8'h00;
        endcase
    endfunction

    // ALU registers its result on the edge that ends the Enable_cal cycle.
    always @(posedge CLK) begin
        if (Enable_cal) begin
            Result_in <= alu(FS, Data_A, Data_B);
            en_count  <= en_count + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reg_is(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        Dbg_sel = idx;
        #1;
        check(tag, {24'h0, Dbg_out}, {24'h0, exp});
    endtask

    initial begin
        RST_N = 1'b0; Instr_ack = 1'b0; Instr_in = 8'h00; Result_in = 8'h00;
        Ld_en = 1'b0; Ld_addr = 2'd0; Ld_data = 8'h00; Dbg_sel = 2'd0;
        #3;
        check("rst_req",  {31'h0, Instr_req}, 32'h0);
        check("rst_en",   {31'h0, Enable_cal}, 32'h0);
        check("rst_halt", {31'h0, Halted}, 32'h0);
        check("rst_pc",   {24'h0, PC_out}, 32'h0);
        check("rst_fs",   {29'h0, FS}, 32'h0);
        check("rst_ab",   {16'h0, Data_A, Data_B}, 32'h0);

        @(posedge CLK); #1;
        RST_N = 1'b1;
        #1;
        check("fetch_req", {31'h0, Instr_req}, 32'h1);

        // Five cycles with no ack while preloading registers.
        Ld_en = 1'b1; Ld_addr = 2'd1; Ld_data = 8'd5;  step(1);
        Ld_addr = 2'd2; Ld_data = 8'd7;  step(1);
        Ld_addr = 2'd0; Ld_data = 8'd3;  step(1);
        Ld_addr = 2'd3; Ld_data = 8'd10; step(1);
        Ld_en = 1'b0; step(1);
        check("wait_req",  {31'h0, Instr_req}, 32'h1);
        check("wait_addr", {24'h0, Instr_addr}, 32'h0);
        check("wait_en",   {31'h0, Enable_cal}, 32'h0);
        reg_is("pre_r1", 2'd1, 8'd5);
        reg_is("pre_r3", 2'd3, 8'd10);

        // ADD R1,R2
        Instr_in = 8'b001_01_10_0; Instr_ack = 1'b1; step(1);
        Instr_ack = 1'b0;
        check("add_dec_req", {31'h0, Instr_req}, 32'h0);
        check("add_dec_en",  {31'h0, Enable_cal}, 32'h0);
        step(1);
        check("add_ex_en", {31'h0, Enable_cal}, 32'h1);
        check("add_ex_fs", {29'h0, FS}, 32'h1);
        check("add_ex_ab", {16'h0, Data_A, Data_B}, 32'h0705);
        check("add_ex_pc", {24'h0, PC_out}, 32'h1);
        step(1);
        check("add_wb_en", {31'h0, Enable_cal}, 32'h0);
        step(1);
        check("add_done_req", {31'h0, Instr_req}, 32'h1);
        reg_is("add_r1", 2'd1, 8'd12);

        // SUB R0,R3 -> R0 = 3 - 10
        Instr_in = 8'b010_00_11_0; Instr_ack = 1'b1; step(1);
        Instr_ack = 1'b0; step(1);
        check("sub_ab", {16'h0, Data_A, Data_B}, 32'h0A03);
        check("sub_fs", {29'h0, FS}, 32'h2);
        step(2);
        reg_is("sub_r0", 2'd0, 8'hF9);

        // MOV R1,R3 with a colliding load to R1 in the WB cycle
        Instr_in = 8'b000_01_11_0; Instr_ack = 1'b1; step(1);
        Instr_ack = 1'b0; step(2);
        Ld_en = 1'b1; Ld_addr = 2'd1; Ld_data = 8'h55; step(1);
        Ld_en = 1'b0;
        reg_is("wb_wins_r1", 2'd1, 8'h0A);

        // ADD R3,R2 with a load to R2 during DECODE: operand keeps old value
        Instr_in = 8'b001_11_10_0; Instr_ack = 1'b1; step(1);
        Instr_ack = 1'b0;
        Ld_en = 1'b1; Ld_addr = 2'd2; Ld_data = 8'h20; step(1);
        Ld_en = 1'b0;
        check("dec_ld_ab", {16'h0, Data_A, Data_B}, 32'h070A);
        step(2);
        reg_is("dec_ld_r3", 2'd3, 8'h11);
        reg_is("dec_ld_r2", 2'd2, 8'h20);
        check("pre_hlt_pc", {24'h0, PC_out}, 32'h4);

        // HLT at PC=4; ack left high to show it is ignored afterwards
        Instr_in = 8'b111_00_00_0; Instr_ack = 1'b1; step(2);
        check("hlt_halted", {31'h0, Halted}, 32'h1);
        check("hlt_req",    {31'h0, Instr_req}, 32'h0);
        check("hlt_en",     {31'h0, Enable_cal}, 32'h0);
        step(20);
        check("hlt_hold_halt", {31'h0, Halted}, 32'h1);
        check("hlt_hold_pc",   {24'h0, PC_out}, 32'h4);
        check("hlt_hold_req",  {31'h0, Instr_req}, 32'h0);
        check("en_pulses",     en_count, 32'd4);

        // Reset exits HALT and clears registers immediately
        Instr_ack = 1'b0;
        RST_N = 1'b0;
        #1;
        check("rst2_halt", {31'h0, Halted}, 32'h0);
        reg_is("rst2_r1", 2'd1, 8'h00);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        Ld_en = 1'b1; Ld_addr = 2'd2; Ld_data = 8'h3C; Instr_in = 8'h00; step(1);
        Ld_en = 1'b0; Instr_ack = 1'b1;

        // 255 zero-wait MOV R0,R0 to bring PC to 255
        step(255 * 4);
        check("pc255",     {24'h0, PC_out}, 32'hFF);
        check("pc255_req", {31'h0, Instr_req}, 32'h1);
        Instr_in = 8'b000_01_10_0; step(1);
        Instr_ack = 1'b0; step(1);
        check("pc_wrap", {24'h0, PC_out}, 32'h0);
        step(2);
        reg_is("mov_r1", 2'd1, 8'h3C);

        // Reset pulsed during EXEC abandons the writeback
        Instr_in = 8'b001_01_10_0; Instr_ack = 1'b1; step(1);
        Instr_ack = 1'b0; step(1);
        check("ex_en", {31'h0, Enable_cal}, 32'h1);
        RST_N = 1'b0;
        #1;
        check("ex_rst_en",  {31'h0, Enable_cal}, 32'h0);
        check("ex_rst_req", {31'h0, Instr_req}, 32'h0);
        check("ex_rst_pc",  {24'h0, PC_out}, 32'h0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        #1;
        check("ex_rel_req", {31'h0, Instr_req}, 32'h1);
        step(3);
        check("ex_rel_req2", {31'h0, Instr_req}, 32'h1);
        reg_is("ex_rel_r1", 2'd1, 8'h00);
        reg_is("ex_rel_r2", 2'd2, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
